aqed_tile_checker: RTL and testbench
====================================

// Module: aqed_tile_checker
// PURPOSE
// Parametrised A-QED harness block for memory-core verification tops; generalises the fixed single-channel
// tile counters, response-bound check and orig/dup compare into one reusable synthesizable monitor.
// Tracks per-channel write/read counts per tile of 'depth', gates further traffic at tile limit, records the
// original tile's output stream on one channel, compares the duplicate tile's stream, and flags bound violations.
// PARAMETERS
// NUM_CH     2   number of monitored memory-core channels
// DATA_W     16  data width per channel
// MAX_DEPTH  64  largest legal runtime depth (capture buffer size)
// CNT_W      17  width of all tile/bound counters
// RD_RATIO   4   reads per write expected before the original tile must complete
// PORTS
// clk          in   1               clock
// reset        in   1               synchronous, active-high
// clk_en       in   1               qualifies all counting/capture
// depth        in   16              tile depth; held constant after reset
// check_ch     in   $clog2(NUM_CH)  channel whose outputs are captured/compared; held constant
// exec_dup     in   1               request: the next tile on check_ch is the duplicate
// wen_in       in   NUM_CH          per-channel write strobe into DUT
// ren_in       in   NUM_CH          per-channel read strobe into DUT
// valid_out    in   NUM_CH          per-channel DUT output valid
// data_out     in   NUM_CH*DATA_W   per-channel DUT output data, ch0 in LSBs
// wen_allow    out  NUM_CH          1 = another write legal this tile
// ren_allow    out  NUM_CH          1 = another read legal this tile
// tile_done    out  NUM_CH          1-cycle pulse at tile wrap
// qed_done     out  1               sticky: duplicate compare finished
// qed_check    out  1               valid with qed_done: 1 = all dup outputs matched orig
// bound_fail   out  1               sticky response-bound violation
// cfg_err      out  1               sticky: depth==0, depth>MAX_DEPTH, or depth/check_ch changed after reset
// BEHAVIOUR
// - Reset: all counters 0, FSM IDLE, buffer pointers 0; wen_allow/ren_allow = all-1, tile_done/qed_done/
//   qed_check/bound_fail/cfg_err = 0. Reset mid-operation aborts any capture/compare; no partial result.
// - Tile counters (per ch c, update only when clk_en): cw[c]+=wen_in[c], cr[c]+=ren_in[c]. Wrap to 0 and pulse
//   tile_done[c] next cycle when post-update cw==depth && cr==depth (covers last wr+rd same cycle, wr-last, rd-last).
// - wen_allow[c] = (cw[c]!=depth); ren_allow[c] = (cr[c]!=depth); combinational from registers. Strobe while
//   allow=0 is ignored for counting and sets cfg_err.
// - FSM on check_ch: IDLE -(first valid_out or wen_in on ch)-> ORIG: push data on each clk_en&valid_out; ->
//   WAIT_DUP after depth pushes (orig_done). WAIT_DUP -(exec_dup seen && tile_done[ch])-> DUP: each valid output
//   compared to buffer[rd_ptr], mismatch clears match flag (init 1); after depth compares -> DONE.
//   DONE: qed_done=1, qed_check=match, terminal until reset. exec_dup before orig_done is latched, not dropped.
// - Outputs in DUP beyond depth impossible (FSM left); extra valid in WAIT_DUP ignored.
// - Response bound: from IDLE exit, count rd_after/wr_after on check_ch (saturating at 2^CNT_W-1). If
//   rd_after>=RD_RATIO*depth && wr_after>=depth && !orig_done -> bound_fail=1 next cycle, sticky.
//   Product computed at CNT_W bits, no overflow for MAX_DEPTH*RD_RATIO < 2^CNT_W (elaboration check).
// - cfg_err: depth/check_ch registered 1 cycle after reset; any later difference or illegal depth sets it.
// - Latency: compare result reaches qed_done/qed_check 1 cycle after the depth-th dup output.
// STRUCTURE
// - aqed_pkg: state enum {IDLE,ORIG,WAIT_DUP,DUP,DONE}, counter-width localparams, channel-slice function.
// - Sub-module aqed_capture_buf: MAX_DEPTH x DATA_W, 1 write port, 1 combinational read port, pointer reset.
// - Per-channel counters in a generate loop; one FSM + bound logic in top.
// TESTING
// - depth=4, ch0 4 wr+4 rd interleaved -> tile_done[0] pulse once, wen_allow[0]=0 after 4th wr until wrap.
// - depth=3, last wr and last rd same cycle -> counters 0 next cycle, no cfg_err.
// - orig outputs 1,2,3,4; exec_dup; dup outputs 1,2,3,4 -> qed_done=1, qed_check=1.
// - same but dup 3rd output 9 -> qed_done=1, qed_check=0 at cycle after 4th dup output.
// - depth=2, 8 reads, 2 writes on check_ch, orig only 1 output -> bound_fail=1, stays 1.
// - depth changed 5->6 mid-run -> cfg_err=1; reset during DUP -> all outputs back to reset values.

Source files
------------

// File: rtl/aqed_tile_checker_pkg.sv
// Shared types, default sizes and helpers for the A-QED tile checker.
package aqed_tile_checker_pkg;

   localparam int unsigned DEF_NUM_CH    = 2;
   localparam int unsigned DEF_DATA_W    = 16;
   localparam int unsigned DEF_MAX_DEPTH = 64;
   localparam int unsigned DEF_CNT_W     = 17;
   localparam int unsigned DEF_RD_RATIO  = 4;
   localparam int unsigned DEPTH_W       = 16;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ORIG     = 3'd1,
      WAIT_DUP = 3'd2,
      DUP      = 3'd3,
      DONE     = 3'd4
   } state_t;

   // Bit offset of channel 'ch' inside a packed per-channel bus of width w
   function automatic int unsigned ch_lsb(input int unsigned ch, input int unsigned w);
      return ch * w;
   endfunction

endpackage

// File: rtl/aqed_tile_checker_capture_buf.sv
// Capture buffer for the original tile's output stream: one write port,
// one combinational read port, separate write/read pointers.
module aqed_tile_checker_capture_buf
   import aqed_tile_checker_pkg::*;
#(
   parameter  int unsigned ENTRIES = DEF_MAX_DEPTH,
   parameter  int unsigned DATA_W  = DEF_DATA_W,
   localparam int unsigned AW      = (ENTRIES > 1) ? $clog2(ENTRIES) : 1,
   localparam int unsigned PTR_W   = $clog2(ENTRIES + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [DATA_W-1:0] wdata,
   input  logic              adv,
   output logic [DATA_W-1:0] rdata,
   output logic [PTR_W-1:0]  wr_cnt,
   output logic [PTR_W-1:0]  rd_cnt
);

   logic [DATA_W-1:0] mem [ENTRIES];

   // Pointer advance; both pointers return to 0 on reset
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_cnt <= '0;
         rd_cnt <= '0;
      end else begin
         if (push) wr_cnt <= wr_cnt + PTR_W'(1);
         if (adv)  rd_cnt <= rd_cnt + PTR_W'(1);
      end
   end

   // Storage array, no reset needed
   always_ff @(posedge clk) begin
      if (push) mem[wr_cnt[AW-1:0]] <= wdata;
   end

   assign rdata = mem[rd_cnt[AW-1:0]];

endmodule

// File: rtl/aqed_tile_checker.sv
// A-QED harness monitor: per-channel tile counters with traffic gating,
// original/duplicate output compare on one channel, response-bound check.
module aqed_tile_checker
   import aqed_tile_checker_pkg::*;
#(
   parameter  int unsigned NUM_CH    = DEF_NUM_CH,
   parameter  int unsigned DATA_W    = DEF_DATA_W,
   parameter  int unsigned MAX_DEPTH = DEF_MAX_DEPTH,
   parameter  int unsigned CNT_W     = DEF_CNT_W,
   parameter  int unsigned RD_RATIO  = DEF_RD_RATIO,
   localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clk_en,
   input  logic [DEPTH_W-1:0]       depth,
   input  logic [CH_W-1:0]          check_ch,
   input  logic                     exec_dup,
   input  logic [NUM_CH-1:0]        wen_in,
   input  logic [NUM_CH-1:0]        ren_in,
   input  logic [NUM_CH-1:0]        valid_out,
   input  logic [NUM_CH*DATA_W-1:0] data_out,
   output logic [NUM_CH-1:0]        wen_allow,
   output logic [NUM_CH-1:0]        ren_allow,
   output logic [NUM_CH-1:0]        tile_done,
   output logic                     qed_done,
   output logic                     qed_check,
   output logic                     bound_fail,
   output logic                     cfg_err
);

   localparam int unsigned PTR_W = $clog2(MAX_DEPTH + 1);

   if (MAX_DEPTH * RD_RATIO >= (1 << CNT_W)) begin : g_bad_cfg
      $error("aqed_tile_checker: MAX_DEPTH*RD_RATIO does not fit in CNT_W bits");
   end

   logic [NUM_CH-1:0] viol;
   logic              ch_valid, ch_wen, ch_ren, ch_td;
   logic [DATA_W-1:0] ch_data, buf_rdata;
   logic [PTR_W-1:0]  wr_cnt, rd_cnt;
   state_t            state, state_nxt;
   logic              push, cmp, push_last, cmp_last;
   logic              match, match_nxt, dup_req;
   logic              active, orig_done;
   logic [CNT_W-1:0]  rd_after, wr_after, rd_limit;
   logic              cfg_cap;
   logic [DEPTH_W-1:0] depth_q;
   logic [CH_W-1:0]   ch_q;

   assign ch_valid = valid_out[check_ch];
   assign ch_wen   = wen_in[check_ch];
   assign ch_ren   = ren_in[check_ch];
   assign ch_td    = tile_done[check_ch];
   assign ch_data  = data_out[ch_lsb(32'(check_ch), DATA_W) +: DATA_W];

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [CNT_W-1:0] cw, cr, cw_nxt, cr_nxt;
      logic             wr_ok, rd_ok, wrap, td;

      assign wen_allow[c] = (cw != CNT_W'(depth));
      assign ren_allow[c] = (cr != CNT_W'(depth));
      assign wr_ok        = clk_en & wen_in[c] & wen_allow[c];
      assign rd_ok        = clk_en & ren_in[c] & ren_allow[c];
      assign viol[c]      = clk_en & ((wen_in[c] & ~wen_allow[c]) | (ren_in[c] & ~ren_allow[c]));
      assign cw_nxt       = cw + CNT_W'(wr_ok);
      assign cr_nxt       = cr + CNT_W'(rd_ok);
      assign wrap         = (wr_ok | rd_ok) & (cw_nxt == CNT_W'(depth)) & (cr_nxt == CNT_W'(depth));
      assign tile_done[c] = td;

      // Tile write/read counters; wrap to zero and pulse when both reach depth
      always_ff @(posedge clk) begin
         if (reset) begin
            cw <= '0;
            cr <= '0;
            td <= 1'b0;
         end else begin
            td <= wrap;
            if (wrap) begin
               cw <= '0;
               cr <= '0;
            end else begin
               cw <= cw_nxt;
               cr <= cr_nxt;
            end
         end
      end
   end

   aqed_tile_checker_capture_buf #(
      .ENTRIES (MAX_DEPTH),
      .DATA_W  (DATA_W)
   ) u_buf (
      .clk    (clk),
      .reset  (reset),
      .push   (push),
      .wdata  (ch_data),
      .adv    (cmp),
      .rdata  (buf_rdata),
      .wr_cnt (wr_cnt),
      .rd_cnt (rd_cnt)
   );

   // Capture/compare FSM state register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // FSM outputs: capture while recording the original, compare in the duplicate
   always_comb begin
      push = 1'b0;
      cmp  = 1'b0;
      case (state)
         IDLE, ORIG: push = clk_en & ch_valid;
         DUP:        cmp  = clk_en & ch_valid;
         default:    ;
      endcase
   end

   assign push_last = push & ((DEPTH_W'(wr_cnt) + DEPTH_W'(1)) == depth);
   assign cmp_last  = cmp  & ((DEPTH_W'(rd_cnt) + DEPTH_W'(1)) == depth);

   // FSM next state; a latched exec_dup waits for the original tile boundary
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (push_last)                        state_nxt = WAIT_DUP;
            else if (clk_en & (ch_valid | ch_wen)) state_nxt = ORIG;
         end
         ORIG:     if (push_last)                    state_nxt = WAIT_DUP;
         WAIT_DUP: if ((dup_req | exec_dup) & ch_td) state_nxt = DUP;
         DUP:      if (cmp_last)                     state_nxt = DONE;
         DONE:     state_nxt = DONE;
         default:  state_nxt = IDLE;
      endcase
   end

   assign match_nxt = match & ~(cmp & (ch_data != buf_rdata));

   // Match flag, duplicate request latch and registered QED result
   always_ff @(posedge clk) begin
      if (reset) begin
         match     <= 1'b1;
         dup_req   <= 1'b0;
         qed_done  <= 1'b0;
         qed_check <= 1'b0;
      end else begin
         match     <= match_nxt;
         if (exec_dup && (state != DUP) && (state != DONE)) dup_req <= 1'b1;
         qed_done  <= (state_nxt == DONE);
         qed_check <= (state_nxt == DONE) & match_nxt;
      end
   end

   assign active    = (state_nxt != IDLE);
   assign orig_done = (state == WAIT_DUP) | (state == DUP) | (state == DONE);
   assign rd_limit  = CNT_W'(RD_RATIO) * CNT_W'(depth);

   // Response bound: raw traffic after leaving IDLE versus original completion
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_after   <= '0;
         wr_after   <= '0;
         bound_fail <= 1'b0;
      end else begin
         if (active & clk_en & ch_ren & (rd_after != '1)) rd_after <= rd_after + CNT_W'(1);
         if (active & clk_en & ch_wen & (wr_after != '1)) wr_after <= wr_after + CNT_W'(1);
         if ((state != IDLE) && (rd_after >= rd_limit) && (wr_after >= CNT_W'(depth)) && !orig_done)
            bound_fail <= 1'b1;
      end
   end

   // Configuration snapshot one cycle after reset and sticky error flag
   always_ff @(posedge clk) begin
      if (reset) begin
         cfg_cap <= 1'b0;
         depth_q <= '0;
         ch_q    <= '0;
         cfg_err <= 1'b0;
      end else begin
         if (!cfg_cap) begin
            cfg_cap <= 1'b1;
            depth_q <= depth;
            ch_q    <= check_ch;
         end
         if ((cfg_cap && ((depth != depth_q) || (check_ch != ch_q))) ||
             (depth == '0) || (depth > DEPTH_W'(MAX_DEPTH)) || (|viol))
            cfg_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_aqed_tile_checker.sv
// Self-checking bench for aqed_tile_checker: directed scenarios plus random
// traffic, all checked cycle by cycle against a queue-based reference model.
module tb_aqed_tile_checker;
   import aqed_tile_checker_pkg::*;

   localparam int unsigned NCH = 2;
   localparam int unsigned DW  = 16;
   localparam int unsigned MD  = 64;
   localparam int unsigned RR  = 4;

   logic              clk = 1'b0;
   logic              reset, clk_en, exec_dup;
   logic [15:0]       depth;
   logic [0:0]        check_ch;
   logic [NCH-1:0]    wen_in, ren_in, valid_out;
   logic [NCH*DW-1:0] data_out;
   logic [NCH-1:0]    wen_allow, ren_allow, tile_done;
   logic              qed_done, qed_check, bound_fail, cfg_err;

   always #5 clk = ~clk;

   aqed_tile_checker dut (
      .clk(clk), .reset(reset), .clk_en(clk_en), .depth(depth), .check_ch(check_ch),
      .exec_dup(exec_dup), .wen_in(wen_in), .ren_in(ren_in), .valid_out(valid_out),
      .data_out(data_out), .wen_allow(wen_allow), .ren_allow(ren_allow),
      .tile_done(tile_done), .qed_done(qed_done), .qed_check(qed_check),
      .bound_fail(bound_fail), .cfg_err(cfg_err)
   );

   int total = 0;
   int bad   = 0;

   // reference model state
   int          m_cw [NCH];
   int          m_cr [NCH];
   bit          m_td [NCH];
   int unsigned orig_q [$];
   bit          m_started, m_dup_req, m_in_dup, m_done, m_mis, m_bound, m_cfg, m_cap;
   int          m_dup_n, m_rd, m_wr;
   int unsigned m_depth_q, m_ch_q;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin
         m_cw[c] = 0; m_cr[c] = 0; m_td[c] = 0;
      end
      orig_q.delete();
      m_started = 0; m_dup_req = 0; m_in_dup = 0; m_done = 0; m_mis = 0;
      m_bound = 0; m_cfg = 0; m_cap = 0; m_dup_n = 0; m_rd = 0; m_wr = 0;
   endtask

   task automatic model_update();
      int d, ch, nw, nr;
      bit td_old, full_old, in_dup_old, v, wa, ra, wok, rok;
      int unsigned dv;
      d          = int'(depth);
      ch         = int'(check_ch);
      td_old     = m_td[ch];
      full_old   = (orig_q.size() == d);
      in_dup_old = m_in_dup;
      v          = clk_en && valid_out[ch];
      dv         = int'(data_out[ch*DW +: DW]);
      // configuration
      if (!m_cap) begin
         m_cap = 1; m_depth_q = depth; m_ch_q = check_ch;
      end else if (depth != m_depth_q || check_ch != m_ch_q) m_cfg = 1;
      if (d == 0 || d > MD) m_cfg = 1;
      // bound uses traffic counted up to the previous cycle
      if (m_started && m_rd >= RR * d && m_wr >= d && !full_old) m_bound = 1;
      // per-channel tile accounting
      for (int c = 0; c < NCH; c++) begin
         wa  = (m_cw[c] != d);
         ra  = (m_cr[c] != d);
         wok = clk_en && wen_in[c] && wa;
         rok = clk_en && ren_in[c] && ra;
         if (clk_en && ((wen_in[c] && !wa) || (ren_in[c] && !ra))) m_cfg = 1;
         nw = m_cw[c] + int'(wok);
         nr = m_cr[c] + int'(rok);
         m_td[c] = 0;
         if ((wok || rok) && nw == d && nr == d) begin
            nw = 0; nr = 0; m_td[c] = 1;
         end
         m_cw[c] = nw; m_cr[c] = nr;
      end
      // original recording starts with the first output or write on the channel
      if (!m_started && clk_en && (valid_out[ch] || wen_in[ch])) m_started = 1;
      if (m_started && !full_old && v) orig_q.push_back(dv);
      // duplicate compare
      if (in_dup_old && !m_done && v) begin
         if (dv != orig_q[m_dup_n]) m_mis = 1;
         m_dup_n++;
         if (m_dup_n == d) m_done = 1;
      end else if (!in_dup_old && full_old && (m_dup_req || exec_dup) && td_old) begin
         m_in_dup = 1;
      end
      if (exec_dup) m_dup_req = 1;
      // raw traffic on the checked channel once recording has begun
      if (m_started && clk_en && ren_in[ch]) m_rd++;
      if (m_started && clk_en && wen_in[ch]) m_wr++;
   endtask

   task automatic compare_all();
      for (int c = 0; c < NCH; c++) begin
         chk_eq($sformatf("wen_allow%0d", c), 32'(wen_allow[c]), 32'(m_cw[c] != int'(depth)));
         chk_eq($sformatf("ren_allow%0d", c), 32'(ren_allow[c]), 32'(m_cr[c] != int'(depth)));
         chk_eq($sformatf("tile_done%0d", c), 32'(tile_done[c]), 32'(m_td[c]));
      end
      chk_eq("qed_done",   32'(qed_done),   32'(m_done));
      chk_eq("qed_check",  32'(qed_check),  32'(m_done && !m_mis));
      chk_eq("bound_fail", 32'(bound_fail), 32'(m_bound));
      chk_eq("cfg_err",    32'(cfg_err),    32'(m_cfg));
   endtask

   task automatic step();
      @(posedge clk);
      if (reset) model_reset();
      else       model_update();
      #1;
      compare_all();
   endtask

   task automatic do_reset(input int d, input int ch);
      depth = 16'(d); check_ch = 1'(ch);
      reset = 1; clk_en = 1; exec_dup = 0;
      wen_in = '0; ren_in = '0; valid_out = '0; data_out = '0;
      step();
      reset = 0;
   endtask

   // one directed cycle on channel 0
   task automatic drv(input bit w, input bit r, input bit v, input int dat, input bit x);
      clk_en    = 1;
      wen_in    = {1'b0, w};
      ren_in    = {1'b0, r};
      valid_out = {1'b0, v};
      data_out  = {16'h0, 16'(dat)};
      exec_dup  = x;
      step();
   endtask

   // orig tile 1..4, then dup tile with given outputs; optional reset after n dup outputs
   task automatic qed_run(input int bad_idx, input int stop_after);
      do_reset(4, 0);
      drv(1, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) drv(1, 0, 0, 0, 0);
      for (int i = 1; i <= 4; i++) drv(0, 1, 1, i, 0);
      drv(0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) drv(1, 0, 0, 0, 0);
      for (int i = 1; i <= 4; i++) begin
         if (i == stop_after + 1) return;
         drv(0, 1, 1, (i == bad_idx) ? 9 : i, 0);
         if (i == 3) chk_eq("qed_done_early", 32'(qed_done), 32'd0);
      end
   endtask

   initial begin
      int tdn;
      bit good;
      reset = 1; clk_en = 0; exec_dup = 0; depth = 16'd4; check_ch = 1'b0;
      wen_in = '0; ren_in = '0; valid_out = '0; data_out = '0;

      // reset values
      do_reset(4, 0);
      chk_eq("rst_wen_allow", 32'(wen_allow), 32'h3);
      chk_eq("rst_ren_allow", 32'(ren_allow), 32'h3);

      // depth 4, interleaved writes and reads on ch0
      tdn = 0;
      for (int i = 0; i < 4; i++) begin
         drv(1, 0, 0, 0, 0);
         tdn += int'(tile_done[0]);
         if (i == 3) chk_eq("wa_after_4th_wr", 32'(wen_allow[0]), 32'd0);
         drv(0, 1, 0, 0, 0);
         tdn += int'(tile_done[0]);
      end
      chk_eq("wrap_pulse", 32'(tile_done[0]), 32'd1);
      chk_eq("wa_after_wrap", 32'(wen_allow[0]), 32'd1);
      for (int i = 0; i < 3; i++) begin
         drv(0, 0, 0, 0, 0);
         tdn += int'(tile_done[0]);
      end
      chk_eq("td_count", 32'(tdn), 32'd1);

      // depth 3, final write and read in the same cycle
      do_reset(3, 0);
      drv(1, 0, 0, 0, 0); drv(1, 0, 0, 0, 0);
      drv(0, 1, 0, 0, 0); drv(0, 1, 0, 0, 0);
      drv(1, 1, 0, 0, 0);
      chk_eq("same_cyc_td", 32'(tile_done[0]), 32'd1);
      chk_eq("same_cyc_wa", 32'(wen_allow[0]), 32'd1);
      chk_eq("same_cyc_ra", 32'(ren_allow[0]), 32'd1);
      chk_eq("same_cyc_cfg", 32'(cfg_err), 32'd0);

      // matching duplicate
      qed_run(0, 4);
      chk_eq("match_done", 32'(qed_done), 32'd1);
      chk_eq("match_check", 32'(qed_check), 32'd1);
      drv(0, 0, 0, 0, 0);
      chk_eq("match_sticky", 32'(qed_done), 32'd1);

      // third duplicate output differs
      qed_run(3, 4);
      chk_eq("mis_done", 32'(qed_done), 32'd1);
      chk_eq("mis_check", 32'(qed_check), 32'd0);

      // reset in the middle of the duplicate compare
      qed_run(0, 2);
      reset = 1; wen_in = '0; ren_in = '0; valid_out = '0; exec_dup = 0;
      step();
      reset = 0;
      chk_eq("rst_dup_wa", 32'(wen_allow), 32'h3);
      chk_eq("rst_dup_ra", 32'(ren_allow), 32'h3);
      chk_eq("rst_dup_td", 32'(tile_done), 32'h0);
      chk_eq("rst_dup_done", 32'(qed_done), 32'd0);
      chk_eq("rst_dup_check", 32'(qed_check), 32'd0);
      chk_eq("rst_dup_bound", 32'(bound_fail), 32'd0);
      chk_eq("rst_dup_cfg", 32'(cfg_err), 32'd0);

      // bound: depth 2, two writes, eight reads, one original output
      do_reset(2, 0);
      drv(1, 0, 0, 0, 0); drv(1, 0, 0, 0, 0);
      drv(0, 1, 1, 7, 0);
      for (int i = 0; i < 7; i++) drv(0, 1, 0, 0, 0);
      chk_eq("bound_not_yet", 32'(bound_fail), 32'd0);
      drv(0, 0, 0, 0, 0);
      chk_eq("bound_set", 32'(bound_fail), 32'd1);
      drv(0, 0, 0, 0, 0);
      chk_eq("bound_sticky", 32'(bound_fail), 32'd1);

      // depth changed after reset
      do_reset(5, 0);
      drv(1, 0, 0, 0, 0); drv(0, 1, 0, 0, 0);
      chk_eq("cfg_stable", 32'(cfg_err), 32'd0);
      depth = 16'd6;
      drv(0, 0, 0, 0, 0);
      chk_eq("cfg_changed", 32'(cfg_err), 32'd1);

      // random traffic against the model
      for (int run = 0; run < 12; run++) begin
         do_reset(int'($urandom_range(1, 6)), int'($urandom_range(0, 1)));
         good = (run % 3 != 2);
         for (int i = 0; i < 250; i++) begin
            clk_en   = ($urandom_range(0, 9) != 0);
            exec_dup = ($urandom_range(0, 19) == 0);
            for (int c = 0; c < NCH; c++) begin
               wen_in[c]    = ($urandom_range(0, 1) == 1) &&
                              ((m_cw[c] != int'(depth)) || ($urandom_range(0, 49) == 0));
               ren_in[c]    = ($urandom_range(0, 1) == 1) &&
                              ((m_cr[c] != int'(depth)) || ($urandom_range(0, 49) == 0));
               valid_out[c] = ($urandom_range(0, 9) < 4);
               data_out[c*DW +: DW] = 16'($urandom_range(0, 15));
            end
            if (good && m_in_dup && !m_done && m_dup_n < orig_q.size())
               data_out[int'(check_ch)*DW +: DW] = 16'(orig_q[m_dup_n]);
            step();
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
